csr_counter_file: RTL and testbench
===================================

Name: csr_counter_file

Overview:
- Second-generation machine CSR block for the scalar core.
- Owns its own 64-bit counters:
  - mcycle
  - minstret with multi-retire increment
  - NumHpm event counters
- Also holds a counter-inhibit register and a scratch register. All machine counters are writable; user read-only shadows are provided.
- Sits beside the decode/execute stage: combinational read port, single write port committed at the clock edge, plus illegal-access flags for the trap logic.

Parameters:
- DWidth, 32, CSR data width; every counter is 2*DWidth bits.
- AWidth, 12, CSR address width.
- NumHpm, 4, number of hpm counters/event selectors, range 0..29, mapped to indices 3..3+NumHpm-1.
- RetireWidth, 2, maximum instructions retired per cycle.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- retire_cnt_i  input  $clog2(RetireWidth+1)  instructions retired this cycle.
- event_i  input  max(NumHpm,1)  per-cycle event pulses; bit k feeds hpm counter 3+k.
- read_addr_i  input  AWidth  CSR read address.
- read_data_o  output  DWidth  read data (combinational).
- read_illegal_o  output  1  read address not implemented.
- write_en_i  input  1  write strobe.
- write_addr_i  input  AWidth  CSR write address.
- write_data_i  input  DWidth  write data.
- write_illegal_o  output  1  write_en_i to an unimplemented or read-only address (combinational).

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high, sampled on the rising edge of clk_i.
- Reset: all counters, mcountinhibit, mhpmevent* and mscratch clear to 0. Outputs are combinational from that state and the read address, so they are 0 or flags only.
- Address map, machine read/write:
  - 0xB00/0xB80 mcycle lo/hi
  - 0xB02/0xB82 minstret lo/hi
  - 0xB03+k/0xB83+k mhpmcounter lo/hi
  - 0x320 mcountinhibit
  - 0x323+k mhpmevent
  - 0x340 mscratch
- Address map, user read-only shadows: 0xC00/0xC80/0xC02/0xC82 and 0xC03+k/0xC83+k.
- mcountinhibit implemented bits are 0 (CY), 2 (IR) and 3..3+NumHpm-1. All other bits read 0, including bit 1, and ignore writes.
- mhpmevent_k: only bit 0 is implemented (count-enable for event_i[k]); other bits read 0.
- Per-cycle counter update when not written:
  - mcycle += 1 unless CY inhibited.
  - minstret += retire_cnt_i unless IR inhibited.
  - hpm_k += 1 when event_i[k] & mhpmevent_k[0] & ~inhibit[3+k].
  - Full 64-bit carry across halves; wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 silently.
- Write to a counter half:
  - Next value = written half replaced by write_data_i, other half unchanged.
  - No increment that cycle for that counter, even if the lower half would have carried.
- Writes to mcountinhibit take effect from the next cycle's increment decision.
- Read:
  - Combinational from current register state.
  - A same-cycle write to the same address returns the old value; the new value is visible the next cycle.
- Illegal accesses:
  - Unimplemented read address: read_data_o = 0, read_illegal_o = 1.
  - Illegal write (unimplemented address or 0xCxx shadow): no state change, write_illegal_o = 1.
  - write_illegal_o = 0 when write_en_i = 0.
- NumHpm = 0: all hpm addresses are illegal; the event_i width is 1 and the bit is ignored.
- Reset asserted together with a write or increment: reset wins.

Test Plan:
- Reset, then 10 idle cycles, retire_cnt_i = 0:
  - read 0xB00 -> 10
  - read 0xB02 -> 0
  - read 0xC00 -> 10
  - read 0x340 -> 0
- Write 0xB00 = 0xFFFF_FFFE, then idle:
  - cycle after write: read 0xB00 -> 0xFFFF_FFFE
  - next cycle: 0xFFFF_FFFF
  - next cycle: lo = 0, and 0xB80 -> 1 (carry across halves).
- Write 0xB82 = 0x5 and 0xB02 = 0xFFFF_FFFF; then retire_cnt_i = 2 for one cycle:
  - minstret = 0x6_0000_0001
  - 0xC82 -> 6
- Write 0x320 = 0x5 (CY and IR inhibited) for 4 cycles with retire_cnt_i = 1: mcycle and minstret unchanged.
  - Write 0x320 = 0x0.
  - Counters resume the following cycle; mcycle increments by exactly 1 per cycle.
- Write 0x323 = 1, then pulse event_i[0] 3 times and event_i[1] 3 times:
  - read 0xB03 -> 3
  - read 0xB04 -> 0
  - read 0x323 with write data 0xFFFF_FFFF -> 1
- Write 0xC00 = 0x1234 -> write_illegal_o = 1, mcycle keeps counting.
  - Read 0x7FF -> read_data_o = 0, read_illegal_o = 1.
  - Write 0x340 = 0xDEAD_BEEF, read 0x340 the same cycle -> 0; next cycle -> 0xDEAD_BEEF.

Source files
------------

// File: rtl/csr_counter_file.sv
// rtl/csr_counter_file.sv - machine counter CSR file with 64-bit counters and user read-only shadows
module csr_counter_file #(
  parameter int DWidth      = 32,
  parameter int AWidth      = 12,
  parameter int NumHpm      = 4,
  parameter int RetireWidth = 2,
  localparam int RcWidth    = $clog2(RetireWidth + 1),
  localparam int EvWidth    = (NumHpm > 0) ? NumHpm : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [RcWidth-1:0] retire_cnt_i,
  input  logic [EvWidth-1:0] event_i,
  input  logic [AWidth-1:0]  read_addr_i,
  output logic [DWidth-1:0]  read_data_o,
  output logic               read_illegal_o,
  input  logic               write_en_i,
  input  logic [AWidth-1:0]  write_addr_i,
  input  logic [DWidth-1:0]  write_data_i,
  output logic               write_illegal_o
);

  localparam int CWidth = 2 * DWidth;
  // Implemented inhibit bits: CY (0), IR (2) and one per hpm counter from bit 3.
  localparam logic [63:0] InhMaskWide = ((64'd1 << (3 + NumHpm)) - 64'd1) & ~64'd2;
  localparam logic [DWidth-1:0] InhMask = InhMaskWide[DWidth-1:0];

  logic [CWidth-1:0] mcycle;
  logic [CWidth-1:0] minstret;
  logic [CWidth-1:0] hpm [EvWidth];
  logic [EvWidth-1:0] hpm_en;
  logic [DWidth-1:0] inhibit;
  logic [DWidth-1:0] mscratch;

  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi, wr_inh, wr_scr, wr_hit;
  logic [EvWidth-1:0] wr_hpm_lo, wr_hpm_hi, wr_evt;

  function automatic logic [AWidth-1:0] csr(input int a);
    return AWidth'(a);
  endfunction

  function automatic logic [DWidth-1:0] pick(input logic [CWidth-1:0] v, input int hi);
    return (hi != 0) ? v[CWidth-1:DWidth] : v[DWidth-1:0];
  endfunction

  // Read port: 0xBxx machine view and 0xCxx user shadow decode to the same counters.
  always_comb begin
    read_data_o    = '0;
    read_illegal_o = 1'b1;
    for (int sh = 0; sh < 2; sh++) begin
      for (int hi = 0; hi < 2; hi++) begin
        if (read_addr_i == csr('hB00 + 'h100 * sh + 'h80 * hi)) begin
          read_data_o    = pick(mcycle, hi);
          read_illegal_o = 1'b0;
        end
        if (read_addr_i == csr('hB02 + 'h100 * sh + 'h80 * hi)) begin
          read_data_o    = pick(minstret, hi);
          read_illegal_o = 1'b0;
        end
        for (int k = 0; k < NumHpm; k++) begin
          if (read_addr_i == csr('hB03 + k + 'h100 * sh + 'h80 * hi)) begin
            read_data_o    = pick(hpm[k], hi);
            read_illegal_o = 1'b0;
          end
        end
      end
    end
    if (read_addr_i == csr('h320)) begin
      read_data_o    = inhibit;
      read_illegal_o = 1'b0;
    end
    for (int k = 0; k < NumHpm; k++) begin
      if (read_addr_i == csr('h323 + k)) begin
        read_data_o    = {{(DWidth-1){1'b0}}, hpm_en[k]};
        read_illegal_o = 1'b0;
      end
    end
    if (read_addr_i == csr('h340)) begin
      read_data_o    = mscratch;
      read_illegal_o = 1'b0;
    end
  end

  // Write decode is ungated; write_en_i is applied at the register update.
  always_comb begin
    wr_cyc_lo = (write_addr_i == csr('hB00));
    wr_cyc_hi = (write_addr_i == csr('hB80));
    wr_ins_lo = (write_addr_i == csr('hB02));
    wr_ins_hi = (write_addr_i == csr('hB82));
    wr_inh    = (write_addr_i == csr('h320));
    wr_scr    = (write_addr_i == csr('h340));
    wr_hpm_lo = '0;
    wr_hpm_hi = '0;
    wr_evt    = '0;
    for (int k = 0; k < NumHpm; k++) begin
      wr_hpm_lo[k] = (write_addr_i == csr('hB03 + k));
      wr_hpm_hi[k] = (write_addr_i == csr('hB83 + k));
      wr_evt[k]    = (write_addr_i == csr('h323 + k));
    end
    wr_hit = wr_cyc_lo | wr_cyc_hi | wr_ins_lo | wr_ins_hi | wr_inh | wr_scr |
             (|wr_hpm_lo) | (|wr_hpm_hi) | (|wr_evt);
  end

  assign write_illegal_o = write_en_i & ~wr_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
      mscratch <= '0;
      hpm_en   <= '0;
      for (int k = 0; k < EvWidth; k++) begin
        hpm[k] <= '0;
      end
    end else begin
      // A write to either half suppresses that counter's increment for the cycle.
      if (write_en_i && wr_cyc_lo) begin
        mcycle[DWidth-1:0] <= write_data_i;
      end else if (write_en_i && wr_cyc_hi) begin
        mcycle[CWidth-1:DWidth] <= write_data_i;
      end else if (!inhibit[0]) begin
        mcycle <= mcycle + CWidth'(1);
      end

      if (write_en_i && wr_ins_lo) begin
        minstret[DWidth-1:0] <= write_data_i;
      end else if (write_en_i && wr_ins_hi) begin
        minstret[CWidth-1:DWidth] <= write_data_i;
      end else if (!inhibit[2]) begin
        minstret <= minstret + CWidth'(retire_cnt_i);
      end

      for (int k = 0; k < NumHpm; k++) begin
        if (write_en_i && wr_hpm_lo[k]) begin
          hpm[k][DWidth-1:0] <= write_data_i;
        end else if (write_en_i && wr_hpm_hi[k]) begin
          hpm[k][CWidth-1:DWidth] <= write_data_i;
        end else if (event_i[k] && hpm_en[k] && !inhibit[3+k]) begin
          hpm[k] <= hpm[k] + CWidth'(1);
        end
        if (write_en_i && wr_evt[k]) begin
          hpm_en[k] <= write_data_i[0];
        end
      end

      if (write_en_i && wr_inh) begin
        inhibit <= write_data_i & InhMask;
      end
      if (write_en_i && wr_scr) begin
        mscratch <= write_data_i;
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_file.sv
// tb/tb_csr_counter_file.sv - directed self-checking bench for csr_counter_file
module tb_csr_counter_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  retire_cnt;
  logic [3:0]  event_v;
  logic [11:0] read_addr;
  logic [31:0] read_data;
  logic        read_illegal;
  logic        write_en;
  logic [11:0] write_addr;
  logic [31:0] write_data;
  logic        write_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_counter_file dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .retire_cnt_i    (retire_cnt),
    .event_i         (event_v),
    .read_addr_i     (read_addr),
    .read_data_o     (read_data),
    .read_illegal_o  (read_illegal),
    .write_en_i      (write_en),
    .write_addr_i    (write_addr),
    .write_data_i    (write_data),
    .write_illegal_o (write_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    cyc();
    write_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    read_addr = a;
    #1;
    chk(tag, read_data, exp);
    chk({tag, "_ill"}, read_illegal, 1'b0);
  endtask

  initial begin
    rst = 1'b1; retire_cnt = '0; event_v = '0; read_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_inhibit", 12'h320, 32'h0);
    chk("rst_wr_ill", write_illegal, 1'b0);

    repeat (10) cyc();
    rd("idle_mcycle", 12'hB00, 32'd10);
    rd("idle_minstret", 12'hB02, 32'd0);
    rd("idle_ucycle", 12'hC00, 32'd10);
    rd("idle_scratch", 12'h340, 32'd0);

    wr(12'hB00, 32'hFFFF_FFFE);
    rd("cy_wr", 12'hB00, 32'hFFFF_FFFE);
    cyc();
    rd("cy_ff", 12'hB00, 32'hFFFF_FFFF);
    cyc();
    rd("cy_carry_lo", 12'hB00, 32'h0);
    rd("cy_carry_hi", 12'hB80, 32'h1);

    wr(12'hB82, 32'h5);
    wr(12'hB02, 32'hFFFF_FFFF);
    retire_cnt = 2'd2;
    cyc();
    retire_cnt = 2'd0;
    rd("ir_lo", 12'hB02, 32'h1);
    rd("ir_hi", 12'hB82, 32'h6);
    rd("ir_uhi", 12'hC82, 32'h6);

    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'd100);
    wr(12'h320, 32'h5);
    retire_cnt = 2'd1;
    repeat (4) cyc();
    rd("inh_cy", 12'hB00, 32'd101);
    rd("inh_ir", 12'hB02, 32'h1);
    wr(12'h320, 32'h0);
    rd("uninh_cy0", 12'hB00, 32'd101);
    cyc();
    rd("uninh_cy1", 12'hB00, 32'd102);
    rd("uninh_ir1", 12'hB02, 32'h2);
    cyc();
    rd("uninh_cy2", 12'hB00, 32'd103);
    retire_cnt = 2'd0;

    wr(12'h323, 32'h1);
    event_v = 4'b0011;
    repeat (3) cyc();
    event_v = 4'b0000;
    rd("hpm3", 12'hB03, 32'd3);
    rd("hpm4_disabled", 12'hB04, 32'd0);
    rd("uhpm3", 12'hC03, 32'd3);
    write_en = 1'b1; write_addr = 12'h323; write_data = 32'hFFFF_FFFF; read_addr = 12'h323;
    #1;
    chk("evt_same_cycle", read_data, 32'h1);
    chk("evt_wr_ill", write_illegal, 1'b0);
    cyc();
    write_en = 1'b0;
    rd("evt_masked", 12'h323, 32'h1);

    wr(12'h320, 32'hFFFF_FFFF);
    rd("inh_mask", 12'h320, 32'h7D);
    event_v = 4'b0001;
    cyc();
    event_v = 4'b0000;
    rd("hpm3_inh", 12'hB03, 32'd3);
    wr(12'h320, 32'h0);

    event_v = 4'b0001;
    wr(12'hB03, 32'hFFFF_FFFF);
    rd("hpm3_wr_noinc", 12'hB03, 32'hFFFF_FFFF);
    cyc();
    event_v = 4'b0000;
    rd("hpm3_carry_lo", 12'hB03, 32'h0);
    rd("hpm3_carry_hi", 12'hB83, 32'h1);

    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    cyc();
    rd("wrap_lo", 12'hB00, 32'h0);
    rd("wrap_hi", 12'hB80, 32'h0);

    wr(12'hB00, 32'd500);
    write_en = 1'b1; write_addr = 12'hC00; write_data = 32'h1234;
    #1;
    chk("shadow_wr_ill", write_illegal, 1'b1);
    cyc();
    write_addr = 12'h327;
    #1;
    chk("hpm_oob_wr_ill", write_illegal, 1'b1);
    write_en = 1'b0;
    #1;
    chk("noen_wr_ill", write_illegal, 1'b0);
    rd("shadow_cy", 12'hB00, 32'd501);
    rd("shadow_ucy", 12'hC00, 32'd501);
    read_addr = 12'h7FF;
    #1;
    chk("bad_rd_data", read_data, 32'h0);
    chk("bad_rd_ill", read_illegal, 1'b1);
    read_addr = 12'hB07;
    #1;
    chk("hpm_oob_rd_ill", read_illegal, 1'b1);
    read_addr = 12'hB01;
    #1;
    chk("time_rd_ill", read_illegal, 1'b1);

    write_en = 1'b1; write_addr = 12'h340; write_data = 32'hDEAD_BEEF; read_addr = 12'h340;
    #1;
    chk("scr_same_cycle", read_data, 32'h0);
    cyc();
    write_en = 1'b0;
    rd("scr_next", 12'h340, 32'hDEAD_BEEF);

    rst = 1'b1;
    write_en = 1'b1; write_addr = 12'h340; write_data = 32'h1;
    cyc();
    rst = 1'b0;
    write_en = 1'b0;
    rd("rstwin_scr", 12'h340, 32'h0);
    rd("rstwin_cy", 12'hB00, 32'h0);
    rd("rstwin_uir", 12'hC02, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
